// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for the Gray counter slice.
// Functions work on a zero-extended MAX_W-bit word, so any WIDTH up to MAX_W converts correctly.
package gray_pkg;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; the zero upper bits leave the low WIDTH bits exact.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step.sv
// Combinational next-state logic for the Gray counter: load > count > hold.
module gray_step
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] MAX_BIN = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = WIDTH'(gray2bin(MAX_W'(load_gray)));
    end else if (en) begin
      if (up_dn) begin
        bin_next  = bin + ONE;
        wrap_next = (bin == MAX_BIN);
      end else begin
        bin_next  = bin - ONE;
        wrap_next = (bin == '0);
      end
    end
    gray_next = WIDTH'(bin2gray(MAX_W'(bin_next)));
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with Gray-coded load; binary and Gray images are registered together.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_BIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_BIN);
  localparam logic [WIDTH-1:0] RST_G = WIDTH'(bin2gray(MAX_W'(RST_BIN)));

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  gray_step #(.WIDTH(WIDTH)) u_step (
    .bin       (bin_out),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_gray (load_gray),
    .bin_next  (bin_next),
    .gray_next (gray_next),
    .wrap_next (wrap_next)
  );

  // Output stage: Gray image is registered, never decoded from bin_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= RST_B;
      gray_out <= RST_G;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      wrap     <= wrap_next;
    end
  end

endmodule
